// File: rtl/cosmos_solver_pkg.sv
// Shared solver definitions: scheduler FSM states, default bank geometry and index sizing.
package cosmos_solver_pkg;

  localparam int NUM_CONS_DEF = 8;
  localparam int DATA_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-slot bank still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/constraint_eval_scheduler_neq_check.sv
// Bitwise inequality test shared by every constraint slot; operands are raw bit patterns.
module neq_check
  import cosmos_solver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              neq
);

  assign neq = |(a ^ b);

endmodule

// File: rtl/constraint_eval_scheduler.sv
// Sequential a != b constraint checker: walks a flop bank one slot per cycle through a single
// comparator, reporting failure count, first failing slot and an all-satisfied flag.
module constraint_eval_scheduler
  import cosmos_solver_pkg::*;
#(
  parameter int NUM_CONS = NUM_CONS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int IDX_W    = idx_width(NUM_CONS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_a,
  input  logic [DATA_W-1:0] cfg_b,
  input  logic              cfg_en,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              all_sat,
  output logic [IDX_W:0]    fail_cnt,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic              first_fail_vld
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONS - 1);
  localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0]   a_q [NUM_CONS];
  logic [DATA_W-1:0]   a_d [NUM_CONS];
  logic [DATA_W-1:0]   b_q [NUM_CONS];
  logic [DATA_W-1:0]   b_d [NUM_CONS];
  logic [NUM_CONS-1:0] en_q, en_d;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              all_sat_q, all_sat_d;
  logic [IDX_W:0]    fail_cnt_q, fail_cnt_d;
  logic [IDX_W-1:0]  ffi_q, ffi_d;
  logic              ffv_q, ffv_d;

  logic              slot_neq;
  logic              slot_fail;

  neq_check #(.DATA_W(DATA_W)) u_neq (
    .a   (a_q[ptr_q]),
    .b   (b_q[ptr_q]),
    .neq (slot_neq)
  );

  assign slot_fail = en_q[ptr_q] & ~slot_neq;

  // Bank writes are locked out during EVAL so the slots under evaluation stay stable.
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    en_d = en_q;
    if (cfg_we && (state_q != ST_EVAL) && (int'(cfg_idx) < NUM_CONS)) begin
      a_d[cfg_idx]  = cfg_a;
      b_d[cfg_idx]  = cfg_b;
      en_d[cfg_idx] = cfg_en;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fail_cnt_d = fail_cnt_q;
    ffi_d      = ffi_q;
    ffv_d      = ffv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_EVAL;
          ptr_d      = '0;
          busy_d     = 1'b1;
          fail_cnt_d = '0;
          ffi_d      = '0;
          ffv_d      = 1'b0;
        end
      end
      ST_EVAL: begin
        if (abort) begin
          state_d    = ST_IDLE;
          ptr_d      = '0;
          busy_d     = 1'b0;
          fail_cnt_d = '0;
          ffi_d      = '0;
          ffv_d      = 1'b0;
        end else begin
          if (slot_fail) begin
            fail_cnt_d = fail_cnt_q + CNT_ONE;
            if (!ffv_q) begin
              ffi_d = ptr_q;
              ffv_d = 1'b1;
            end
          end
          if (ptr_q == LAST_IDX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
    all_sat_d = (fail_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      all_sat_q  <= 1'b1;
      fail_cnt_q <= '0;
      ffi_q      <= '0;
      ffv_q      <= 1'b0;
      a_q        <= '{default: '0};
      b_q        <= '{default: '0};
      en_q       <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      all_sat_q  <= all_sat_d;
      fail_cnt_q <= fail_cnt_d;
      ffi_q      <= ffi_d;
      ffv_q      <= ffv_d;
      a_q        <= a_d;
      b_q        <= b_d;
      en_q       <= en_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign all_sat        = all_sat_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_vld = ffv_q;

endmodule
